// File: rtl/sccb_init_pkg.sv
// Shared definitions for the OV5640 SCCB init sequencer: state encoding and
// register-table entry layout.
package sccb_init_pkg;

   localparam int unsigned STATE_W = 4;

   localparam logic [STATE_W-1:0] S_PWDN  = 4'd0;
   localparam logic [STATE_W-1:0] S_RSTW  = 4'd1;
   localparam logic [STATE_W-1:0] S_INITW = 4'd2;
   localparam logic [STATE_W-1:0] S_LOAD  = 4'd3;
   localparam logic [STATE_W-1:0] S_START = 4'd4;
   localparam logic [STATE_W-1:0] S_SHIFT = 4'd5;
   localparam logic [STATE_W-1:0] S_ACK   = 4'd6;
   localparam logic [STATE_W-1:0] S_STOP  = 4'd7;
   localparam logic [STATE_W-1:0] S_GAP   = 4'd8;
   localparam logic [STATE_W-1:0] S_DONE  = 4'd9;
   localparam logic [STATE_W-1:0] S_ERR   = 4'd10;

   localparam int unsigned LUT_ADDR_W  = 16;
   localparam int unsigned LUT_DATA_W  = 8;
   localparam int unsigned LUT_ENTRY_W = LUT_ADDR_W + LUT_DATA_W;

   typedef struct packed {
      logic [LUT_ADDR_W-1:0] reg_addr;
      logic [LUT_DATA_W-1:0] data;
   } lut_entry_t;

endpackage

// File: rtl/ov5640_cam_top.sv
// Camera-side wrapper: sequencer plus register table, with open-drain SCCB pads.
module ov5640_cam_top #(
   parameter int unsigned CLK_HZ = 27_000_000
) (
   input  logic I_clk,
   input  logic I_rst_n,
   inout  wire  cmos_scl,
   inout  wire  cmos_sda,
   output logic O_cmos_pwdn,
   output logic O_cmos_rst_n,
   output logic O_busy,
   output logic O_done,
   output logic O_err
);

   logic        scl_oe;
   logic        sda_oe;
   logic [7:0]  lut_index;
   logic [7:0]  lut_size;
   logic [23:0] lut_data;

   assign cmos_scl = scl_oe ? 1'b0 : 1'bz;
   assign cmos_sda = sda_oe ? 1'b0 : 1'bz;

   sccb_init #(
      .CLK_HZ (CLK_HZ)
   ) u_sccb_init (
      .I_clk        (I_clk),
      .I_rst_n      (I_rst_n),
      .O_scl_oe     (scl_oe),
      .O_sda_oe     (sda_oe),
      .I_sda        (cmos_sda),
      .O_lut_index  (lut_index),
      .I_lut_data   (lut_data),
      .I_lut_size   (lut_size),
      .O_cmos_pwdn  (O_cmos_pwdn),
      .O_cmos_rst_n (O_cmos_rst_n),
      .O_busy       (O_busy),
      .O_done       (O_done),
      .O_err        (O_err)
   );

   ov5640_reg_lut u_reg_lut (
      .I_index (lut_index),
      .O_entry (lut_data),
      .O_size  (lut_size)
   );

endmodule

// File: rtl/ov5640_reg_lut.sv
// OV5640 register table: combinational lookup of {reg_addr, data} by index.
module ov5640_reg_lut
   import sccb_init_pkg::*;
(
   input  logic [7:0]             I_index,
   output logic [LUT_ENTRY_W-1:0] O_entry,
   output logic [7:0]             O_size
);

   localparam int unsigned NUM_ENTRIES = 5;

   lut_entry_t entry;

   always_comb begin
      entry = '0;
      case (I_index)
         8'd0:    entry = '{reg_addr: 16'h3008, data: 8'h82};
         8'd1:    entry = '{reg_addr: 16'h3008, data: 8'h42};
         8'd2:    entry = '{reg_addr: 16'h3103, data: 8'h03};
         8'd3:    entry = '{reg_addr: 16'h3017, data: 8'hff};
         8'd4:    entry = '{reg_addr: 16'h3018, data: 8'hff};
         default: entry = '0;
      endcase
   end

   assign O_entry = entry;
   assign O_size  = 8'(NUM_ENTRIES);

endmodule

// File: rtl/sccb_init.sv
// OV5640 power-up sequencer and SCCB register writer: walks a register table and
// writes each entry as a 4-byte SCCB transaction, retrying on NACK.
module sccb_init
   import sccb_init_pkg::*;
#(
   parameter int unsigned CLK_HZ    = 27_000_000,
   parameter int unsigned SCL_HZ    = 100_000,
   parameter logic [7:0]  DEV_ADDR  = 8'h78,
   parameter int unsigned T_PWDN    = 27_000,
   parameter int unsigned T_RST     = 27_000,
   parameter int unsigned T_INIT    = 540_000,
   parameter int unsigned MAX_RETRY = 3
) (
   input  logic                   I_clk,
   input  logic                   I_rst_n,
   output logic                   O_scl_oe,
   output logic                   O_sda_oe,
   input  logic                   I_sda,
   output logic [7:0]             O_lut_index,
   input  logic [LUT_ENTRY_W-1:0] I_lut_data,
   input  logic [7:0]             I_lut_size,
   output logic                   O_cmos_pwdn,
   output logic                   O_cmos_rst_n,
   output logic                   O_busy,
   output logic                   O_done,
   output logic                   O_err
);

   localparam int unsigned QTR      = CLK_HZ / (4 * SCL_HZ);
   localparam logic [15:0] QTR_LAST = 16'(QTR - 1);

   logic [STATE_W-1:0] state_q, state_d;
   logic [31:0]        cnt_q, cnt_d;
   logic [15:0]        qcnt_q, qcnt_d;
   logic [1:0]         quarter_q, quarter_d;
   logic [2:0]         bit_q, bit_d;
   logic [1:0]         byte_q, byte_d;
   logic [7:0]         retry_q, retry_d;
   logic               nack_q, nack_d;
   logic [31:0]        frame_q, frame_d;
   logic [7:0]         index_q, index_d;
   logic               scl_oe_q, scl_oe_d;
   logic               sda_oe_q, sda_oe_d;
   logic               qend;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      qcnt_d    = qcnt_q;
      quarter_d = quarter_q;
      bit_d     = bit_q;
      byte_d    = byte_q;
      retry_d   = retry_q;
      nack_d    = nack_q;
      frame_d   = frame_q;
      index_d   = index_q;
      qend      = (qcnt_q == QTR_LAST);

      // Bus states share one quarter-bit timebase
      if (state_q inside {S_START, S_SHIFT, S_ACK, S_STOP, S_GAP}) begin
         qcnt_d = qend ? 16'd0 : qcnt_q + 16'd1;
         if (qend) quarter_d = quarter_q + 2'd1;
      end

      case (state_q)
         S_PWDN: begin
            if (cnt_q == 32'(T_PWDN - 1)) begin
               state_d = S_RSTW;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         S_RSTW: begin
            if (cnt_q == 32'(T_RST - 1)) begin
               state_d = S_INITW;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         S_INITW: begin
            if (cnt_q == 32'(T_INIT - 1)) begin
               state_d = (I_lut_size == 8'd0) ? S_DONE : S_LOAD;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         S_LOAD: begin
            if (index_q == I_lut_size) begin
               state_d = S_DONE;
            end else begin
               frame_d   = {DEV_ADDR, I_lut_data};
               state_d   = S_START;
               qcnt_d    = '0;
               quarter_d = '0;
               bit_d     = '0;
               byte_d    = '0;
               nack_d    = 1'b0;
            end
         end
         S_START: begin
            if (qend && quarter_q == 2'd2) begin
               state_d   = S_SHIFT;
               quarter_d = '0;
            end
         end
         S_SHIFT: begin
            if (qend && quarter_q == 2'd3) begin
               frame_d = {frame_q[30:0], 1'b0};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = S_ACK;
            end
         end
         S_ACK: begin
            if (qend && quarter_q == 2'd2) nack_d = I_sda;
            if (qend && quarter_q == 2'd3) begin
               byte_d  = byte_q + 2'd1;
               state_d = (nack_q || byte_q == 2'd3) ? S_STOP : S_SHIFT;
            end
         end
         S_STOP: begin
            if (qend && quarter_q == 2'd2) begin
               state_d   = S_GAP;
               quarter_d = '0;
            end
         end
         S_GAP: begin
            if (qend && quarter_q == 2'd3) begin
               if (!nack_q) begin
                  index_d = index_q + 8'd1;
                  retry_d = '0;
                  state_d = S_LOAD;
               end else if (retry_q == 8'(MAX_RETRY)) begin
                  state_d = S_ERR;
               end else begin
                  retry_d = retry_q + 8'd1;
                  state_d = S_LOAD;
               end
            end
         end
         S_DONE, S_ERR: ;
         default: state_d = S_PWDN;
      endcase
   end

   // Pad enables are decoded from next-state values so the flops track the phase exactly
   always_comb begin
      scl_oe_d = 1'b0;
      sda_oe_d = 1'b0;
      case (state_d)
         S_START: begin
            scl_oe_d = (quarter_d == 2'd2);
            sda_oe_d = (quarter_d != 2'd0);
         end
         S_SHIFT: begin
            scl_oe_d = (quarter_d == 2'd0) || (quarter_d == 2'd3);
            sda_oe_d = ~frame_d[31];
         end
         S_ACK: scl_oe_d = (quarter_d == 2'd0) || (quarter_d == 2'd3);
         S_STOP: begin
            scl_oe_d = (quarter_d == 2'd0);
            sda_oe_d = (quarter_d != 2'd2);
         end
         default: ;
      endcase
   end

   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         state_q      <= S_PWDN;
         cnt_q        <= '0;
         qcnt_q       <= '0;
         quarter_q    <= '0;
         bit_q        <= '0;
         byte_q       <= '0;
         retry_q      <= '0;
         nack_q       <= 1'b0;
         frame_q      <= '0;
         index_q      <= '0;
         scl_oe_q     <= 1'b0;
         sda_oe_q     <= 1'b0;
         O_cmos_pwdn  <= 1'b1;
         O_cmos_rst_n <= 1'b0;
         O_busy       <= 1'b1;
         O_done       <= 1'b0;
         O_err        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         qcnt_q       <= qcnt_d;
         quarter_q    <= quarter_d;
         bit_q        <= bit_d;
         byte_q       <= byte_d;
         retry_q      <= retry_d;
         nack_q       <= nack_d;
         frame_q      <= frame_d;
         index_q      <= index_d;
         scl_oe_q     <= scl_oe_d;
         sda_oe_q     <= sda_oe_d;
         O_cmos_pwdn  <= (state_d == S_PWDN);
         O_cmos_rst_n <= !(state_d == S_PWDN || state_d == S_RSTW);
         O_busy       <= !(state_d == S_DONE || state_d == S_ERR);
         O_done       <= (state_d == S_DONE);
         O_err        <= (state_d == S_ERR);
      end
   end

   assign O_scl_oe    = scl_oe_q;
   assign O_sda_oe    = sda_oe_q;
   assign O_lut_index = index_q;

endmodule

// File: tb/tb_sccb_init.sv
// Directed bench for sccb_init: power sequencing, SCCB byte stream decoded by a
// slave model, NACK retry/error paths, empty table and mid-transaction reset.
module tb_sccb_init;

   logic        I_clk = 1'b0;
   logic        I_rst_n = 1'b0;
   logic        O_scl_oe, O_sda_oe, I_sda;
   logic [7:0]  O_lut_index;
   logic [23:0] I_lut_data;
   logic [7:0]  I_lut_size;
   logic        O_cmos_pwdn, O_cmos_rst_n, O_busy, O_done, O_err;

   logic [23:0] lut_mem [4];

   sccb_init #(
      .CLK_HZ    (4_000_000),
      .SCL_HZ    (100_000),
      .DEV_ADDR  (8'h78),
      .T_PWDN    (20),
      .T_RST     (30),
      .T_INIT    (40),
      .MAX_RETRY (3)
   ) dut (
      .I_clk        (I_clk),
      .I_rst_n      (I_rst_n),
      .O_scl_oe     (O_scl_oe),
      .O_sda_oe     (O_sda_oe),
      .I_sda        (I_sda),
      .O_lut_index  (O_lut_index),
      .I_lut_data   (I_lut_data),
      .I_lut_size   (I_lut_size),
      .O_cmos_pwdn  (O_cmos_pwdn),
      .O_cmos_rst_n (O_cmos_rst_n),
      .O_busy       (O_busy),
      .O_done       (O_done),
      .O_err        (O_err)
   );

   always #5 I_clk = ~I_clk;

   assign I_lut_data = (O_lut_index < 8'd4) ? lut_mem[O_lut_index[1:0]] : 24'h0;

   // Slave model: decodes START/STOP/bytes from the open-drain lines and drives ACK
   int          nack_mode;  // 0 = always ACK, 1 = NACK first frame only, 2 = always NACK
   logic        drive_ack, in_frame, scl_p, sda_p, scl_seen;
   logic        scl_l, sda_l;
   logic [7:0]  shreg;
   logic [7:0]  bytes_seen [64];
   int          bitcnt, n_bytes, n_starts, n_stops, n_acks;

   assign scl_l = ~O_scl_oe;
   assign sda_l = ~(O_sda_oe | drive_ack);
   assign I_sda = sda_l;

   always @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         drive_ack <= 1'b0;
         in_frame  <= 1'b0;
         scl_p     <= 1'b1;
         sda_p     <= 1'b1;
         scl_seen  <= 1'b0;
         shreg     <= '0;
         bitcnt    <= 0;
         n_bytes   <= 0;
         n_starts  <= 0;
         n_stops   <= 0;
         n_acks    <= 0;
      end else begin
         scl_p <= scl_l;
         sda_p <= sda_l;
         if (O_scl_oe) scl_seen <= 1'b1;
         if (scl_l && scl_p && sda_p && !sda_l) begin
            in_frame <= 1'b1;
            bitcnt   <= 0;
            n_starts <= n_starts + 1;
         end else if (scl_l && scl_p && !sda_p && sda_l) begin
            in_frame <= 1'b0;
            n_stops  <= n_stops + 1;
         end else if (in_frame && scl_l && !scl_p) begin
            if (bitcnt < 8) begin
               shreg <= {shreg[6:0], sda_l};
               if (bitcnt == 7 && n_bytes < 64) begin
                  bytes_seen[n_bytes[5:0]] <= {shreg[6:0], sda_l};
                  n_bytes <= n_bytes + 1;
               end
               bitcnt <= bitcnt + 1;
            end else begin
               if (!sda_l) n_acks <= n_acks + 1;
               bitcnt <= 0;
            end
         end else if (in_frame && !scl_l && scl_p) begin
            drive_ack <= (bitcnt == 8) && !(nack_mode == 2 || (nack_mode == 1 && n_starts == 1));
         end
      end
   end

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      I_rst_n = 1'b0;
      repeat (3) @(posedge I_clk);
      @(negedge I_clk);
      I_rst_n = 1'b1;
   endtask

   task automatic wait_end(input int budget, output int cycles);
      cycles = 0;
      while (!(O_done || O_err) && cycles < budget) begin
         @(posedge I_clk);
         #1;
         cycles++;
      end
      check("end_reached", {31'b0, O_done | O_err}, 32'd1);
   endtask

   task automatic check_bytes(input string tag, input int first, input logic [31:0] exp);
      for (int i = 0; i < 4; i++)
         check(tag, {24'b0, bytes_seen[6'(first + i)]}, {24'b0, exp[31-8*i -: 8]});
   endtask

   initial begin
      int t_pwdn, t_rst, t_sda, cyc;

      nack_mode  = 0;
      I_lut_size = 8'd1;
      lut_mem[0] = 24'h300882;
      lut_mem[1] = 24'h310303;
      lut_mem[2] = 24'h0;
      lut_mem[3] = 24'h0;

      // Reset state and power sequence timing
      repeat (2) @(posedge I_clk);
      #1;
      check("rst_pwdn", {31'b0, O_cmos_pwdn}, 32'd1);
      check("rst_cam_rst_n", {31'b0, O_cmos_rst_n}, 32'd0);
      check("rst_scl_oe", {31'b0, O_scl_oe}, 32'd0);
      check("rst_sda_oe", {31'b0, O_sda_oe}, 32'd0);
      check("rst_busy", {31'b0, O_busy}, 32'd1);
      check("rst_done", {31'b0, O_done}, 32'd0);
      check("rst_err", {31'b0, O_err}, 32'd0);
      check("rst_index", {24'b0, O_lut_index}, 32'd0);
      @(negedge I_clk);
      I_rst_n = 1'b1;
      t_pwdn = 0;
      t_rst  = 0;
      t_sda  = 0;
      for (int k = 1; k <= 200; k++) begin
         @(posedge I_clk);
         #1;
         if (t_pwdn == 0 && !O_cmos_pwdn) t_pwdn = k;
         if (t_rst == 0 && O_cmos_rst_n) t_rst = k;
         if (t_sda == 0 && O_sda_oe) t_sda = k;
      end
      check("pwdn_fall_cycle", t_pwdn, 32'd20);
      check("rst_rise_cycle", t_rst, 32'd50);
      check("first_sda_cycle", t_sda, 32'd101);

      // Single entry, all ACKed
      wait_end(5000, cyc);
      check("s2_done", {31'b0, O_done}, 32'd1);
      check("s2_err", {31'b0, O_err}, 32'd0);
      check("s2_busy", {31'b0, O_busy}, 32'd0);
      check("s2_index", {24'b0, O_lut_index}, 32'd1);
      check("s2_nbytes", n_bytes, 32'd4);
      check_bytes("s2_byte", 0, 32'h78300882);
      check("s2_acks", n_acks, 32'd4);
      check("s2_stops", n_stops, 32'd1);
      check("s2_lines", {30'b0, O_scl_oe, O_sda_oe}, 32'd0);

      // NACK on first attempt only
      nack_mode = 1;
      do_reset();
      wait_end(8000, cyc);
      check("s3_done", {31'b0, O_done}, 32'd1);
      check("s3_err", {31'b0, O_err}, 32'd0);
      check("s3_starts", n_starts, 32'd2);
      check("s3_stops", n_stops, 32'd2);
      check("s3_nbytes", n_bytes, 32'd5);
      check("s3_byte0", {24'b0, bytes_seen[0]}, 32'h78);
      check_bytes("s3_retry_byte", 1, 32'h78300882);
      check("s3_index", {24'b0, O_lut_index}, 32'd1);

      // Always NACK: four attempts then error
      nack_mode = 2;
      do_reset();
      wait_end(10000, cyc);
      check("s4_err", {31'b0, O_err}, 32'd1);
      check("s4_done", {31'b0, O_done}, 32'd0);
      check("s4_busy", {31'b0, O_busy}, 32'd0);
      check("s4_lines", {30'b0, O_scl_oe, O_sda_oe}, 32'd0);
      check("s4_starts", n_starts, 32'd4);
      check("s4_stops", n_stops, 32'd4);
      check("s4_index", {24'b0, O_lut_index}, 32'd0);
      repeat (50) @(posedge I_clk);
      #1;
      check("s4_err_held", {31'b0, O_err}, 32'd1);

      // Empty table: done straight after the INITW wait, no bus activity
      nack_mode  = 0;
      I_lut_size = 8'd0;
      do_reset();
      wait_end(1000, cyc);
      check("s5_done_cycle", cyc, 32'd90);
      check("s5_done", {31'b0, O_done}, 32'd1);
      check("s5_busy", {31'b0, O_busy}, 32'd0);
      check("s5_scl_seen", {31'b0, scl_seen}, 32'd0);
      check("s5_starts", n_starts, 32'd0);

      // Reset pulse during byte 2, then full rerun over two entries
      I_lut_size = 8'd2;
      do_reset();
      cyc = 0;
      while (n_bytes < 1 && cyc < 1000) begin
         @(posedge I_clk);
         #1;
         cyc++;
      end
      check("s6_first_byte", n_bytes, 32'd1);
      repeat (100) @(posedge I_clk);
      @(negedge I_clk);
      I_rst_n = 1'b0;
      #1;
      check("s6_rst_scl_oe", {31'b0, O_scl_oe}, 32'd0);
      check("s6_rst_sda_oe", {31'b0, O_sda_oe}, 32'd0);
      check("s6_rst_pwdn", {31'b0, O_cmos_pwdn}, 32'd1);
      check("s6_rst_cam_rst_n", {31'b0, O_cmos_rst_n}, 32'd0);
      repeat (2) @(posedge I_clk);
      @(negedge I_clk);
      I_rst_n = 1'b1;
      wait_end(8000, cyc);
      check("s6_done", {31'b0, O_done}, 32'd1);
      check("s6_index", {24'b0, O_lut_index}, 32'd2);
      check("s6_nbytes", n_bytes, 32'd8);
      check_bytes("s6_e0_byte", 0, 32'h78300882);
      check_bytes("s6_e1_byte", 4, 32'h78310303);
      check("s6_stops", n_stops, 32'd2);
      check("s6_acks", n_acks, 32'd8);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
